disp_fetch: RTL and testbench



---
 rtl/disp_fetch_if.sv | 42 ++++
 rtl/disp_fetch.sv | 186 ++++++++++++++++++
 tb/tb_disp_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_fetch_if.sv
// ---------------------------------------------------------------------------
// disp_fetch_if : AXI4 read address / read data channels used by the display
//                 frame fetcher.
//
// Handshake rule (both channels): a transfer happens on the rising clock edge
// where VALID and READY are both high. Once the source raises VALID, it holds
// VALID and its payload stable until that edge. READY may change freely.
//
// Signals
//   ARADDR  [31:0] burst start byte address        (master -> slave)
//   ARLEN   [7:0]  beats per burst minus one        (master -> slave)
//   ARSIZE  [2:0]  bytes per beat code, 8 bytes     (master -> slave)
//   ARBURST [1:0]  burst type, INCR                 (master -> slave)
//   ARVALID        address valid                    (master -> slave)
//   ARREADY        address accepted                 (slave  -> master)
//   RDATA   [63:0] read data beat                   (slave  -> master)
//   RVALID         read data valid                  (slave  -> master)
//   RLAST          last beat of the burst           (slave  -> master)
//   RREADY         read data accepted               (master -> slave)
// ---------------------------------------------------------------------------
interface disp_fetch_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RLAST;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RVALID, RLAST
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RVALID, RLAST
    );
endinterface

// File: rtl/disp_fetch.sv
// ---------------------------------------------------------------------------
// disp_fetch : AXI4 read master that streams one frame of pixel data from the
//              frame buffer into the display FIFO stage.
//
// Each 64-bit beat carries two 0x00RRGGBB pixels and is forwarded to the FIFO
// one cycle after it is accepted. A burst is requested only while the FIFO
// reports room for a whole burst. Every frame start resets the FIFO.
//
// Ports
//   i_aclk         clock
//   i_arst         synchronous active-high reset
//   i_dispon       display enable
//   i_dispaddr     frame base byte address (8-byte aligned), sampled at start
//   i_frame_start  one-cycle frame start pulse
//   i_buf_wready   FIFO has room for one burst
//   axi            AXI4 read channels (master side)
//   o_fiforst      one-cycle FIFO reset pulse at each frame start
//   o_fifoin       beat written to the FIFO
//   o_fifowr       FIFO write strobe
//   o_busy         frame fetch in progress (state != IDLE)
//   o_state        current FSM state, for observation
// ---------------------------------------------------------------------------
module disp_fetch #(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480,
    parameter int BURST_LEN = 16
) (
    input  logic         i_aclk,
    input  logic         i_arst,
    input  logic         i_dispon,
    input  logic [31:0]  i_dispaddr,
    input  logic         i_frame_start,
    input  logic         i_buf_wready,
    disp_fetch_if.master axi,
    output logic         o_fiforst,
    output logic [63:0]  o_fifoin,
    output logic         o_fifowr,
    output logic         o_busy,
    output logic [1:0]   o_state
);

    localparam int NWORDS  = H_PIXELS * V_LINES / 2;
    localparam int NBURSTS = NWORDS / BURST_LEN;
    localparam int BSTEP   = BURST_LEN * 8;
    localparam int CW      = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
    localparam logic [CW-1:0] LAST_BURST = CW'(NBURSTS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAITBUF = 2'd1,
        S_ADDR    = 2'd2,
        S_DATA    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_base;
    logic [31:0]   r_araddr;
    logic          r_arvalid;
    logic [CW-1:0] r_cnt;
    logic          r_restart;
    logic          r_fiforst;
    logic          r_fifowr;
    logic [63:0]   r_fifoin;

    logic          w_fs_req;     // frame start that is allowed to act
    logic          w_start;      // perform the frame-start action this cycle
    logic          w_issue;      // launch the next burst address
    logic          w_cnt_inc;    // advance to the next burst of the frame
    logic          w_beat;       // read beat accepted this cycle
    logic          w_end_burst;  // last beat of the burst accepted
    logic [31:0]   w_addr;

    assign w_fs_req    = i_frame_start & i_dispon;
    assign w_beat      = (r_state == S_DATA) & axi.RVALID;
    assign w_end_burst = w_beat & axi.RLAST;
    // Address arithmetic wraps at 32 bits.
    assign w_addr      = r_base + (32'(r_cnt) * 32'(BSTEP));

    // Next-state / control decode.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fs_req) begin
                    w_start      = 1'b1;
                    w_next_state = S_WAITBUF;
                end
            end
            S_WAITBUF: begin
                // No burst is in flight here, so a new frame restarts at once.
                if (w_fs_req) begin
                    w_start = 1'b1;
                end else if (!i_dispon) begin
                    w_next_state = S_IDLE;
                end else if (i_buf_wready) begin
                    w_issue      = 1'b1;
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi.ARREADY) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                // Only RLAST ends the burst; a pending restart is honoured
                // here so an accepted burst is never abandoned on the bus.
                // A frame start coinciding with RLAST counts as pending.
                if (w_end_burst) begin
                    if (r_restart || w_fs_req) begin
                        w_start      = 1'b1;
                        w_next_state = S_WAITBUF;
                    end else if ((r_cnt == LAST_BURST) || !i_dispon) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_cnt_inc    = 1'b1;
                        w_next_state = S_WAITBUF;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_arst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_cnt     <= '0;
            r_restart <= 1'b0;
            r_fiforst <= 1'b0;
            r_fifowr  <= 1'b0;
            r_fifoin  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_fiforst <= w_start;
            r_fifowr  <= w_beat;
            if (w_beat) begin
                r_fifoin <= axi.RDATA;
            end

            if (w_start) begin
                r_base <= i_dispaddr;
                r_cnt  <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Remember a frame start that arrived while a burst is in flight.
            if (w_start) begin
                r_restart <= 1'b0;
            end else if (w_fs_req && (r_state != S_IDLE)) begin
                r_restart <= 1'b1;
            end

            if (w_issue) begin
                r_araddr  <= w_addr;
                r_arvalid <= 1'b1;
            end else if ((r_state == S_ADDR) && axi.ARREADY) begin
                r_arvalid <= 1'b0;
            end
        end
    end

    assign axi.ARADDR  = r_araddr;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'b011;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = (r_state == S_DATA);

    assign o_fiforst = r_fiforst;
    assign o_fifoin  = r_fifoin;
    assign o_fifowr  = r_fifowr;
    assign o_busy    = (r_state != S_IDLE);
    assign o_state   = r_state;

endmodule

// File: tb/tb_disp_fetch.sv
// ---------------------------------------------------------------------------
// tb_disp_fetch : directed + randomized bench for disp_fetch.
// A small memory-slave model answers AR/R requests with random data; every
// accepted beat is queued and must reappear on the FIFO port one cycle later.
// Burst addresses are predicted from the frame base and burst index.
// ---------------------------------------------------------------------------
module tb_disp_fetch;

    localparam int H_PIXELS  = 64;
    localparam int V_LINES   = 2;
    localparam int BURST_LEN = 16;
    localparam int BSTEP     = BURST_LEN * 8;
    localparam int NBURSTS   = H_PIXELS * V_LINES / 2 / BURST_LEN;
    localparam int NBEATS    = NBURSTS * BURST_LEN;

    logic        clk;
    logic        arst;
    logic        dispon;
    logic [31:0] dispaddr;
    logic        frame_start;
    logic        buf_wready;
    logic        o_fiforst;
    logic [63:0] o_fifoin;
    logic        o_fifowr;
    logic        o_busy;
    logic [1:0]  o_state;

    disp_fetch_if axi();

    disp_fetch #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .i_aclk       (clk),
        .i_arst       (arst),
        .i_dispon     (dispon),
        .i_dispaddr   (dispaddr),
        .i_frame_start(frame_start),
        .i_buf_wready (buf_wready),
        .axi          (axi),
        .o_fiforst    (o_fiforst),
        .o_fifoin     (o_fifoin),
        .o_fifowr     (o_fifowr),
        .o_busy       (o_busy),
        .o_state      (o_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard and model state
    logic [63:0] exp_q[$];
    int          n_vec, n_err, cyc;
    int          n_ar, n_wr, n_rst, n_arv, n_hold, n_rlast;
    int          beats_left, beat_in_burst, last_rlast_cyc;
    int          exp_burst, ar_seen, ar_delay, ar_delay_cur;
    logic        in_burst, restart_pending;
    logic        r_gap, r_phase, rnd, rnd_buf;
    logic        p_arvalid, p_rready;
    logic [31:0] exp_base, pend_base, p_araddr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_counts();
        n_ar = 0; n_wr = 0; n_rst = 0; n_arv = 0; n_hold = 0; n_rlast = 0;
    endtask

    // One clock: observe just after the edge, update the model, then drive
    // the slave inputs for the next edge.
    task automatic step();
        logic        rst_e, arready_e, rvalid_e, rlast_e;
        logic [63:0] rdata_e, tmp;
        logic [31:0] ea;
        rst_e     = arst;
        arready_e = axi.ARREADY;
        rvalid_e  = axi.RVALID;
        rlast_e   = axi.RLAST;
        rdata_e   = axi.RDATA;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_e) begin
            exp_q.delete();
            beats_left = 0;
            in_burst = 1'b0;
            restart_pending = 1'b0;
        end else begin
            if (p_arvalid && arready_e) begin
                ea = exp_base + (32'(exp_burst) * 32'(BSTEP));
                check("araddr", 64'(p_araddr), 64'(ea));
                exp_burst++;
                n_ar++;
                beats_left = BURST_LEN;
                beat_in_burst = 0;
                in_burst = 1'b1;
            end else if (p_arvalid) begin
                check("ar_hold_valid", 64'(axi.ARVALID), 64'(1));
                check("ar_hold_addr", 64'(axi.ARADDR), 64'(p_araddr));
                n_hold++;
            end
            if (rvalid_e && p_rready) begin
                exp_q.push_back(rdata_e);
                beats_left--;
                beat_in_burst++;
                if (rlast_e) begin
                    in_burst = 1'b0;
                    last_rlast_cyc = cyc;
                    n_rlast++;
                    if (restart_pending) begin
                        check("fiforst_restart", 64'(o_fiforst), 64'(1));
                        exp_base = pend_base;
                        exp_burst = 0;
                        restart_pending = 1'b0;
                    end
                end
            end
        end
        check("fifowr", 64'(o_fifowr), 64'(exp_q.size() != 0));
        if (o_fifowr) n_wr++;
        if (exp_q.size() != 0) begin
            tmp = exp_q.pop_front();
            if (o_fifowr) check("fifoin", o_fifoin, tmp);
        end
        check("rready", 64'(axi.RREADY), 64'(in_burst));
        if (o_fiforst) n_rst++;
        if (axi.ARVALID) n_arv++;
        p_arvalid = axi.ARVALID;
        p_araddr  = axi.ARADDR;
        p_rready  = axi.RREADY;

        // slave drive for the next edge
        if (axi.ARVALID) begin
            if (ar_seen == 0) ar_delay_cur = rnd ? int'($urandom_range(0, 3)) : ar_delay;
            axi.ARREADY = (ar_seen >= ar_delay_cur);
            ar_seen++;
        end else begin
            axi.ARREADY = 1'b0;
            ar_seen = 0;
        end
        r_phase = ~r_phase;
        if (beats_left > 0 && (rnd ? ($urandom_range(0, 1) == 1) : (!r_gap || r_phase))) begin
            axi.RVALID = 1'b1;
            axi.RLAST  = (beats_left == 1);
        end else begin
            axi.RVALID = 1'b0;
            axi.RLAST  = 1'b0;
        end
        axi.RDATA = {$urandom(), $urandom()};
        if (rnd_buf) buf_wready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic start_frame(input logic [31:0] addr);
        exp_base    = addr;
        exp_burst   = 0;
        dispaddr    = addr;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (o_busy && i < budget) begin
            step();
            i++;
        end
        check("idle_timeout", 64'(o_busy), 64'(0));
    endtask

    task automatic wait_beats(input int nar, input int nb, input int budget);
        int i;
        i = 0;
        while (!(n_ar == nar && beat_in_burst >= nb) && i < budget) begin
            step();
            i++;
        end
        check("beat_timeout", 64'(n_ar == nar && beat_in_burst >= nb), 64'(1));
    endtask

    initial begin
        logic [31:0] base;
        n_vec = 0; n_err = 0; cyc = 0;
        reset_counts();
        beats_left = 0; beat_in_burst = 0; last_rlast_cyc = 0;
        exp_burst = 0; ar_seen = 0; ar_delay = 0; ar_delay_cur = 0;
        in_burst = 1'b0; restart_pending = 1'b0;
        r_gap = 1'b0; r_phase = 1'b0; rnd = 1'b0; rnd_buf = 1'b0;
        p_arvalid = 1'b0; p_rready = 1'b0; p_araddr = '0;
        exp_base = '0; pend_base = '0;
        arst = 1'b1; dispon = 1'b0; dispaddr = '0; frame_start = 1'b0; buf_wready = 1'b0;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RDATA = '0;

        // reset values
        repeat (3) step();
        check("rst_arvalid", 64'(axi.ARVALID), 64'(0));
        check("rst_araddr", 64'(axi.ARADDR), 64'(0));
        check("rst_fiforst", 64'(o_fiforst), 64'(0));
        check("rst_fifoin", o_fifoin, 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("arlen", 64'(axi.ARLEN), 64'(BURST_LEN - 1));
        check("arsize", 64'(axi.ARSIZE), 64'(3));
        check("arburst", 64'(axi.ARBURST), 64'(1));
        arst = 1'b0;
        dispon = 1'b1;
        buf_wready = 1'b1;
        step();

        // full frame, no back-pressure
        reset_counts();
        start_frame(32'h1000_0000);
        check("t1_fiforst", 64'(o_fiforst), 64'(1));
        check("t1_busy", 64'(o_busy), 64'(1));
        step();
        check("t1_fiforst_1cyc", 64'(o_fiforst), 64'(0));
        wait_idle(400);
        check("t1_bursts", 64'(n_ar), 64'(NBURSTS));
        check("t1_writes", 64'(n_wr), 64'(NBEATS));
        check("t1_fiforst_cnt", 64'(n_rst), 64'(1));
        check("t1_busy_drop", 64'(cyc), 64'(last_rlast_cyc));

        // FIFO full for 50 cycles
        reset_counts();
        buf_wready = 1'b0;
        start_frame(32'h2000_0000);
        repeat (49) step();
        check("t2_no_arvalid", 64'(n_arv), 64'(0));
        check("t2_busy", 64'(o_busy), 64'(1));
        buf_wready = 1'b1;
        step();
        check("t2_arvalid_first", 64'(axi.ARVALID), 64'(1));
        wait_idle(400);
        check("t2_bursts", 64'(n_ar), 64'(NBURSTS));
        check("t2_writes", 64'(n_wr), 64'(NBEATS));

        // slow ARREADY, gapped RVALID
        reset_counts();
        ar_delay = 5;
        r_gap = 1'b1;
        start_frame(32'h3000_0040);
        wait_idle(1000);
        check("t3_hold_cycles", 64'(n_hold), 64'(5 * NBURSTS));
        check("t3_bursts", 64'(n_ar), 64'(NBURSTS));
        check("t3_writes", 64'(n_wr), 64'(NBEATS));
        ar_delay = 0;
        r_gap = 1'b0;

        // restart during beat 7 of burst 2
        reset_counts();
        start_frame(32'h4000_0000);
        wait_beats(2, 6, 300);
        restart_pending = 1'b1;
        pend_base = 32'h5000_0100;
        dispaddr = pend_base;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t4_no_early_rst", 64'(o_fiforst), 64'(0));
        for (int i = 0; i < 100 && restart_pending; i++) step();
        check("t4_restart_taken", 64'(restart_pending), 64'(0));
        check("t4_burst2_writes", 64'(n_wr), 64'(2 * BURST_LEN));
        wait_idle(400);
        check("t4_bursts", 64'(n_ar), 64'(2 + NBURSTS));
        check("t4_writes", 64'(n_wr), 64'(2 * BURST_LEN + NBEATS));
        check("t4_fiforst_cnt", 64'(n_rst), 64'(2));

        // DISPON dropped while waiting for FIFO room
        reset_counts();
        buf_wready = 1'b0;
        start_frame(32'h6000_0000);
        repeat (3) step();
        dispon = 1'b0;
        step();
        check("t5_wait_drop_busy", 64'(o_busy), 64'(0));
        buf_wready = 1'b1;
        repeat (5) step();
        check("t5_wait_drop_noar", 64'(n_arv), 64'(0));

        // DISPON dropped mid-burst
        reset_counts();
        dispon = 1'b1;
        start_frame(32'h7000_0000);
        wait_beats(1, 3, 100);
        dispon = 1'b0;
        wait_idle(200);
        check("t5_data_drop_bursts", 64'(n_ar), 64'(1));
        check("t5_data_drop_writes", 64'(n_wr), 64'(BURST_LEN));

        // FRAME_START ignored while disabled
        reset_counts();
        start_frame(32'h7100_0000);
        repeat (10) step();
        check("t5_off_busy", 64'(o_busy), 64'(0));
        check("t5_off_fiforst", 64'(n_rst), 64'(0));
        check("t5_off_noar", 64'(n_arv), 64'(0));
        dispon = 1'b1;

        // randomized frames, last one wraps the 32-bit address space
        rnd = 1'b1;
        rnd_buf = 1'b1;
        for (int f = 0; f < 3; f++) begin
            reset_counts();
            base = (f == 2) ? 32'hFFFF_FF80 : ($urandom() & 32'hFFFF_FFF8);
            start_frame(base);
            wait_idle(3000);
            check("t6_bursts", 64'(n_ar), 64'(NBURSTS));
            check("t6_writes", 64'(n_wr), 64'(NBEATS));
        end
        rnd = 1'b0;
        rnd_buf = 1'b0;
        buf_wready = 1'b1;

        // reset in the middle of a burst
        reset_counts();
        start_frame(32'h8000_0000);
        wait_beats(1, 5, 100);
        arst = 1'b1;
        step();
        check("t7_arvalid", 64'(axi.ARVALID), 64'(0));
        check("t7_araddr", 64'(axi.ARADDR), 64'(0));
        check("t7_rready", 64'(axi.RREADY), 64'(0));
        check("t7_fifowr", 64'(o_fifowr), 64'(0));
        check("t7_fifoin", o_fifoin, 64'(0));
        check("t7_fiforst", 64'(o_fiforst), 64'(0));
        check("t7_busy", 64'(o_busy), 64'(0));
        arst = 1'b0;
        repeat (5) step();
        check("t7_stay_idle", 64'(o_busy), 64'(0));
        reset_counts();
        start_frame(32'h9000_0000);
        wait_idle(400);
        check("t7_recover_writes", 64'(n_wr), 64'(NBEATS));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
